// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider, start/ready handshake, {remainder, quotient} result
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUSY    = 2'd1;
   localparam logic [1:0] S_DIVZERO = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]         r_state;
   logic [WIDTH-1:0]   r_dividend;
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_rem;
   logic [CW-1:0]      r_cnt;
   logic               r_q_neg;
   logic               r_r_neg;
   logic [2*WIDTH-1:0] r_result;
   logic               r_ready;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rem_next;
   logic [WIDTH-1:0]   w_quot_next;
   logic [WIDTH-1:0]   w_rem_fin;
   logic [WIDTH-1:0]   w_quot_fin;

   assign w_a_neg = signed_div_i & opdata1_i[WIDTH-1];
   assign w_b_neg = signed_div_i & opdata2_i[WIDTH-1];
   assign w_a_abs = w_a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
   assign w_b_abs = w_b_neg ? (~opdata2_i + 1'b1) : opdata2_i;

   // Quotient bits shift into the dividend register's vacated LSBs, so it ends up holding the quotient.
   assign w_shift     = {r_rem, r_dividend[WIDTH-1]};
   assign w_ge        = (w_shift >= {1'b0, r_divisor});
   assign w_rem_next  = w_ge ? (w_shift[WIDTH-1:0] - r_divisor) : w_shift[WIDTH-1:0];
   assign w_quot_next = {r_dividend[WIDTH-2:0], w_ge};
   assign w_rem_fin   = r_r_neg ? (~w_rem_next + 1'b1) : w_rem_next;
   assign w_quot_fin  = r_q_neg ? (~w_quot_next + 1'b1) : w_quot_next;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_q_neg    <= 1'b0;
         r_r_neg    <= 1'b0;
         r_result   <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     r_dividend <= opdata1_i;
                     r_state    <= S_DIVZERO;
                  end else begin
                     r_dividend <= w_a_abs;
                     r_divisor  <= w_b_abs;
                     r_q_neg    <= w_a_neg ^ w_b_neg;
                     r_r_neg    <= w_a_neg;
                     r_rem      <= '0;
                     r_cnt      <= '0;
                     r_state    <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (annul_i || !start_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem      <= w_rem_next;
                  r_dividend <= w_quot_next;
                  r_cnt      <= r_cnt + CW'(1);
                  if (r_cnt == LAST_ITER) begin
                     r_result <= {w_rem_fin, w_quot_fin};
                     r_ready  <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_DIVZERO: begin
               if (annul_i || !start_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_result <= {r_dividend, {WIDTH{1'b1}}};
                  r_ready  <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized and directed checks of seq_divider against an arithmetic model
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          exp_done = -1;
   logic [63:0] exp_val = '0;
   logic [63:0] m_result = '0;

   seq_divider #(.WIDTH(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      if (b == 0) return {a, 32'hFFFFFFFF};
      if (!s) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Observed every cycle: ready exactly in the predicted cycle, result equal to the last completed value.
   always @(negedge clk) begin
      logic exp_ready;
      if (!resetn) m_result = '0;
      else if (cyc == exp_done) m_result = exp_val;
      exp_ready = resetn && (cyc == exp_done);
      chk("ready", {63'd0, ready_o}, {63'd0, exp_ready});
      chk("result", result_o, m_result);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 complete, 1 annul at cycle 'at', 2 drop start at 'at', 3 reset at 'at'
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int kind, input int at);
      int lat;
      step();
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = s;
      start_i      = 1'b1;
      lat = (b == 0) ? 2 : 33;
      if (kind == 0) begin
         exp_val  = model(a, b, s);
         exp_done = cyc + lat;
      end
      for (int k = 1; k <= lat; k++) begin
         step();
         if (kind != 0 && k == at) begin
            if (kind == 1) annul_i = 1'b1;
            else if (kind == 2) start_i = 1'b0;
            else begin
               start_i  = 1'b0;
               resetn   = 1'b0;
               exp_done = -1;
               #1;
               chk("reset_ready_async", {63'd0, ready_o}, 64'd0);
               chk("reset_result_async", result_o, 64'd0);
            end
         end else if (kind != 0 && k == at + 1) begin
            annul_i = 1'b0;
            start_i = 1'b0;
            resetn  = 1'b1;
            return;
         end
         if (kind == 0 && k == lat) start_i = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      int          r, kind, at;

      #1;
      chk("por_ready", {63'd0, ready_o}, 64'd0);
      chk("por_result", result_o, 64'd0);
      repeat (3) step();
      resetn = 1'b1;

      do_op(32'd100, 32'd7, 1'b0, 0, 0);
      chk("u100_7", result_o, 64'h00000002_0000000E);
      do_op(32'hFFFFFFF9, 32'h2, 1'b1, 0, 0);
      chk("s-7_2", result_o, 64'hFFFFFFFF_FFFFFFFD);
      do_op(32'hFFFFFFF9, 32'h2, 1'b0, 0, 0);
      chk("u-7_2", result_o, 64'h00000001_7FFFFFFC);
      do_op(32'd5, 32'd0, 1'b1, 0, 0);
      chk("s5_0", result_o, 64'h00000005_FFFFFFFF);
      do_op(32'd5, 32'd0, 1'b0, 0, 0);
      chk("u5_0", result_o, 64'h00000005_FFFFFFFF);
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0);
      chk("s_ovf", result_o, 64'h00000000_80000000);
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0);
      chk("u_ovf", result_o, 64'h80000000_00000000);

      do_op(32'd100, 32'd7, 1'b0, 1, 10);
      chk("annul_keeps", result_o, 64'h80000000_00000000);
      do_op(32'd9, 32'd3, 1'b0, 0, 0);
      chk("u9_3", result_o, 64'h00000000_00000003);

      // annul_i held together with start_i in IDLE: nothing may be accepted
      step();
      opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
      repeat (40) step();
      start_i = 1'b0; annul_i = 1'b0;
      chk("idle_annul_keeps", result_o, 64'h00000000_00000003);

      do_op(32'd100, 32'd7, 1'b0, 3, 15);
      chk("post_reset_result", result_o, 64'd0);
      do_op(32'd20, 32'd6, 1'b0, 0, 0);
      chk("b2b_1", result_o, 64'h00000002_00000003);
      do_op(32'd7, 32'hFFFFFFFE, 1'b1, 0, 0);
      chk("b2b_2", result_o, 64'h00000001_FFFFFFFD);
      do_op(32'd7, 32'd0, 1'b0, 2, 1);
      chk("divzero_abort_keeps", result_o, 64'h00000001_FFFFFFFD);

      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         if (r == 0) b = 32'd0;
         else if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         else if (r == 2) b = $urandom_range(1, 15);
         else if (r == 3) b = -($urandom_range(1, 15));
         kind = 0;
         at   = 0;
         if ($urandom_range(0, 7) == 0) begin
            kind = $urandom_range(1, 2);
            at   = (b == 0) ? 1 : $urandom_range(1, 32);
         end
         do_op(a, b, s, kind, at);
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
